// File: rtl/comparator_pool1.sv
// comparator_pool1 -- pipelined binary16 "A < B" comparator for 2-to-1 max pooling.
//
// Operands arrive on two AXI-Stream slave channels (A and B) and are consumed
// only as a pair. The one-bit result (plus an optional unordered flag) travels
// through a LATENCY-deep register pipeline to the RESULT master channel.
//
// Handshake rule used on every channel: a beat transfers on a rising aclk edge
// where tvalid and tready are both high. A master holds tdata/tvalid stable
// until the beat transfers. Here S_AXIS_A_tready and S_AXIS_B_tready equal the
// pipeline advance signal, so a lone valid operand simply waits for its partner.
//
// Optional build macro: COMP_UNORDERED_FLAG_EN
//   defined     -> M_AXIS_RESULT_tdata[1] = 1 when either operand is NaN
//   not defined -> M_AXIS_RESULT_tdata[1] = 0
// Bit 0 (A < B) is identical in both builds.

module comparator_pool1 #(
  parameter int LATENCY = 5  // cycles from input handshake to RESULT tvalid, 1..8
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [15:0] S_AXIS_A_tdata,
  input  logic        S_AXIS_A_tvalid,
  output logic        S_AXIS_A_tready,
  input  logic [15:0] S_AXIS_B_tdata,
  input  logic        S_AXIS_B_tvalid,
  output logic        S_AXIS_B_tready,
  output logic [7:0]  M_AXIS_RESULT_tdata,
  output logic        M_AXIS_RESULT_tvalid,
  input  logic        M_AXIS_RESULT_tready
);

  // Per-stage payload: bit 0 = A < B, bit 1 = unordered flag.
  localparam int RW = 2;

  logic [LATENCY-1:0] stage_vld;
  logic [RW-1:0]      stage_res [LATENCY];

  logic adv;
  logic fire;

  logic a_sign, b_sign;
  logic [14:0] a_mag, b_mag;
  logic a_nan, b_nan;
  logic both_zero;
  logic cmp_lt;
  logic cmp_unord;

  // The pipeline moves whenever the output slot is empty or being drained.
  // Readiness is forced low while reset is held so nothing is taken then.
  assign adv  = ~M_AXIS_RESULT_tvalid | M_AXIS_RESULT_tready;
  assign fire = S_AXIS_A_tvalid & S_AXIS_B_tvalid & adv;

  assign S_AXIS_A_tready = adv & aresetn;
  assign S_AXIS_B_tready = adv & aresetn;

  // Field split and NaN detection for both operands.
  always_comb begin
    a_sign    = S_AXIS_A_tdata[15];
    b_sign    = S_AXIS_B_tdata[15];
    a_mag     = S_AXIS_A_tdata[14:0];
    b_mag     = S_AXIS_B_tdata[14:0];
    a_nan     = (S_AXIS_A_tdata[14:10] == 5'h1F) && (S_AXIS_A_tdata[9:0] != 10'd0);
    b_nan     = (S_AXIS_B_tdata[14:10] == 5'h1F) && (S_AXIS_B_tdata[9:0] != 10'd0);
    both_zero = (a_mag == 15'd0) && (b_mag == 15'd0);
  end

  // Sign-magnitude ordering: NaN is unordered, +0 == -0, negatives reverse
  // the magnitude order, and a sign mismatch is decided by A's sign alone.
  always_comb begin
    cmp_lt = 1'b0;
    if (a_nan || b_nan) begin
      cmp_lt = 1'b0;
    end else if (both_zero) begin
      cmp_lt = 1'b0;
    end else if (a_sign != b_sign) begin
      cmp_lt = a_sign;
    end else if (!a_sign) begin
      cmp_lt = (a_mag < b_mag);
    end else begin
      cmp_lt = (a_mag > b_mag);
    end
  end

  // Unordered flag only exists in the flagged build; otherwise tied low.
`ifdef COMP_UNORDERED_FLAG_EN
  assign cmp_unord = a_nan | b_nan;
`else
  assign cmp_unord = 1'b0;
`endif

  // Shift register pipeline: stage 0 captures the pair, later stages follow.
  // Every stage holds still when the output is stalled, so no beat is lost.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stage_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stage_res[i] <= '0;
      end
    end else if (adv) begin
      stage_vld[0] <= fire;
      stage_res[0] <= fire ? {cmp_unord, cmp_lt} : '0;
      for (int i = 1; i < LATENCY; i++) begin
        stage_vld[i] <= stage_vld[i-1];
        stage_res[i] <= stage_res[i-1];
      end
    end
  end

  assign M_AXIS_RESULT_tvalid = stage_vld[LATENCY-1];
  assign M_AXIS_RESULT_tdata  = {6'd0, stage_res[LATENCY-1]};

endmodule

// File: tb/tb_comparator_pool1.sv
// tb_comparator_pool1 -- randomized and directed bench for comparator_pool1.
// Expected results come from an ordering-key model: each non-NaN binary16
// value maps to a signed integer whose order matches the real-number order.

module tb_comparator_pool1;

  localparam int LAT = 5;

  // ---------------- clock / reset ----------------
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] a_dat = '0;
  logic        a_vld = 1'b0;
  logic        a_rdy;
  logic [15:0] b_dat = '0;
  logic        b_vld = 1'b0;
  logic        b_rdy;
  logic [7:0]  r_dat;
  logic        r_vld;
  logic        r_rdy = 1'b0;

  always #5 aclk = ~aclk;

  comparator_pool1 #(.LATENCY(LAT)) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .S_AXIS_A_tdata       (a_dat),
    .S_AXIS_A_tvalid      (a_vld),
    .S_AXIS_A_tready      (a_rdy),
    .S_AXIS_B_tdata       (b_dat),
    .S_AXIS_B_tvalid      (b_vld),
    .S_AXIS_B_tready      (b_rdy),
    .M_AXIS_RESULT_tdata  (r_dat),
    .M_AXIS_RESULT_tvalid (r_vld),
    .M_AXIS_RESULT_tready (r_rdy)
  );

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_del = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat = '0;

`ifdef COMP_UNORDERED_FLAG_EN
  localparam logic [7:0] NAN_RES = 8'd2;
`else
  localparam logic [7:0] NAN_RES = 8'd0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
  endfunction

  // Signed ordering key: +0 and -0 both map to 0, negatives to -magnitude.
  function automatic int order_key(input logic [15:0] v);
    int mag;
    mag = int'(v[14:0]);
    return v[15] ? -mag : mag;
  endfunction

  function automatic logic [7:0] ref_res(input logic [15:0] a, input logic [15:0] b);
    logic [7:0] r;
    bit unord;
    unord = is_nan(a) || is_nan(b);
    r = 8'd0;
    if (!unord && (order_key(a) < order_key(b))) r[0] = 1'b1;
`ifdef COMP_UNORDERED_FLAG_EN
    r[1] = unord;
`endif
    return r;
  endfunction

  function automatic logic [15:0] rand_half();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0: v = {1'($urandom), 5'h1F, 10'($urandom_range(1, 1023))};
      1: v = {1'($urandom), 15'd0};
      2: v = {1'($urandom), 5'h1F, 10'd0};
      3: v = {1'($urandom), 5'd0, 10'($urandom)};
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  // Sampled on the falling edge; the beats seen here transfer on the next rise.
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      check("s_ready_a", a_rdy, (!r_vld) || r_rdy);
      check("s_ready_b", b_rdy, a_rdy);
      if (prev_stall) begin
        check("stall_vld_hold", r_vld, 1'b1);
        check("stall_dat_hold", r_dat, prev_dat);
      end
      if (a_vld && b_vld && a_rdy) exp_q.push_back(ref_res(a_dat, b_dat));
      if (r_vld && r_rdy) begin
        check("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("result", r_dat, exp_q.pop_front());
        n_del++;
      end
      prev_stall = r_vld && !r_rdy;
      prev_dat   = r_dat;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Single pair with RESULT always ready: checks acceptance, latency and value.
  task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] expv);
    int lat;
    a_dat = a; b_dat = b; a_vld = 1'b1; b_vld = 1'b1; r_rdy = 1'b1;
    @(negedge aclk);
    check({tag, "_ready"}, a_rdy, 1'b1);
    tick();
    a_vld = 1'b0; b_vld = 1'b0;
    lat = 1;
    while (!r_vld && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_data"}, r_dat, expv);
  endtask

  // Stream n random pairs back to back with an optional RESULT stall window.
  task automatic run_stream(input int n, input int stall_at, input int stall_len);
    int sent, cyc, d0, t;
    logic taken;
    sent = 0; cyc = 0; d0 = n_del;
    a_dat = rand_half(); b_dat = rand_half();
    while (sent < n && cyc < 200) begin
      a_vld = 1'b1; b_vld = 1'b1;
      r_rdy = !((cyc >= stall_at) && (cyc < stall_at + stall_len));
      @(negedge aclk);
      taken = a_rdy;
      if (!r_rdy && r_vld) check("stall_no_accept", a_rdy, 1'b0);
      tick();
      cyc++;
      if (taken) begin
        sent++;
        a_dat = rand_half(); b_dat = rand_half();
      end
    end
    a_vld = 1'b0; b_vld = 1'b0; r_rdy = 1'b1;
    t = 0;
    while ((n_del - d0) < n && t < 40) begin
      tick();
      t++;
    end
    repeat (3) tick();
    check("stream_count", n_del - d0, n);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic a_taken, b_taken;
    int d0;

    // Reset state.
    #1;
    check("rst_tvalid", r_vld, 1'b0);
    check("rst_tdata", r_dat, 8'd0);
    check("rst_tready", a_rdy, 1'b0);
    repeat (3) tick();
    aresetn = 1'b1;
    tick();

    // Directed compare vectors.
    send_one("one_lt_two", 16'h3C00, 16'h4000, 8'd1);
    send_one("two_lt_one", 16'h4000, 16'h3C00, 8'd0);
    send_one("equal_neg",  16'hC200, 16'hC200, 8'd0);
    send_one("neg_pos_zero", 16'h8000, 16'h0000, 8'd0);
    send_one("ninf_lt_m2", 16'hFC00, 16'hC000, 8'd1);
    send_one("nan_a",      16'h7E00, 16'h3C00, NAN_RES);
    send_one("nan_b",      16'h3C00, 16'hFE01, NAN_RES);
    send_one("neg_vs_pos", 16'hBC00, 16'h0001, 8'd1);
    send_one("subn_order", 16'h0001, 16'h0002, 8'd1);
    send_one("pinf_lt_x",  16'h7C00, 16'h7BFF, 8'd0);
    tick();

    // Eight pairs back to back with a 3-cycle RESULT stall in the middle.
    run_stream(8, 6, 3);

    // Lone A waits for B; exactly one result for the pair.
    d0 = n_del;
    a_dat = 16'h4400; a_vld = 1'b1; b_vld = 1'b0; r_rdy = 1'b1;
    repeat (4) begin
      tick();
      check("lone_a_no_result", r_vld, 1'b0);
    end
    check("lone_a_no_pair", exp_q.size(), 0);
    b_dat = 16'h4200; b_vld = 1'b1;
    tick();
    a_vld = 1'b0; b_vld = 1'b0;
    repeat (LAT + 8) tick();
    check("lone_a_one_result", n_del - d0, 1);

    // Reset with three pairs in flight.
    r_rdy = 1'b0;
    a_vld = 1'b1; b_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_dat = rand_half(); b_dat = rand_half();
      tick();
    end
    a_vld = 1'b0; b_vld = 1'b0;
    repeat (LAT) tick();
    check("pre_reset_valid", r_vld, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    check("async_rst_tvalid", r_vld, 1'b0);
    check("async_rst_tdata", r_dat, 8'd0);
    check("async_rst_tready", a_rdy, 1'b0);
    exp_q.delete();
    repeat (2) tick();
    aresetn = 1'b1;
    r_rdy = 1'b1;
    repeat (LAT + 6) tick();
    check("no_stale_result", r_vld, 1'b0);

    // Randomized traffic with random backpressure and operand arrival.
    a_taken = 1'b0; b_taken = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (!a_vld || a_taken) begin
        a_vld = ($urandom_range(0, 3) != 0);
        a_dat = rand_half();
      end
      if (!b_vld || b_taken) begin
        b_vld = ($urandom_range(0, 3) != 0);
        b_dat = ($urandom_range(0, 7) == 0) ? a_dat : rand_half();
      end
      r_rdy = ($urandom_range(0, 3) != 0);
      @(negedge aclk);
      a_taken = a_vld && b_vld && a_rdy;
      b_taken = a_taken;
      tick();
    end

    // Drain.
    a_vld = 1'b0; b_vld = 1'b0; r_rdy = 1'b1;
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) tick();
    repeat (2) tick();
    check("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
